// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer.
package seq_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned FUN_W  = 3;
   localparam int unsigned ALU_W  = 5;
   localparam int unsigned RF_N   = 4;
   localparam int unsigned ARF_N  = 3;
   localparam int unsigned T_W    = 3;

   typedef enum logic [2:0] {
      S_CLEAR, S_IDLE, S_FETCH_LO, S_FETCH_HI, S_EXEC1, S_EXEC2, S_HALT
   } state_e;

   localparam logic [OP_W-1:0] OP_BRA = 6'h00;
   localparam logic [OP_W-1:0] OP_LDI = 6'h01;
   localparam logic [OP_W-1:0] OP_LD  = 6'h02;
   localparam logic [OP_W-1:0] OP_ST  = 6'h03;
   localparam logic [OP_W-1:0] OP_ADD = 6'h04;
   localparam logic [OP_W-1:0] OP_SUB = 6'h05;
   localparam logic [OP_W-1:0] OP_AND = 6'h06;
   localparam logic [OP_W-1:0] OP_ORR = 6'h07;
   localparam logic [OP_W-1:0] OP_BNE = 6'h08;
   localparam logic [OP_W-1:0] OP_HLT = 6'h3F;

   localparam logic [FUN_W-1:0] FUN_DEC  = 3'b000;
   localparam logic [FUN_W-1:0] FUN_INC  = 3'b001;
   localparam logic [FUN_W-1:0] FUN_LOAD = 3'b010;
   localparam logic [FUN_W-1:0] FUN_CLR  = 3'b011;

   localparam logic [ALU_W-1:0] ALU_PASS_A = 5'b10000;
   localparam logic [ALU_W-1:0] ALU_ADD    = 5'b10100;
   localparam logic [ALU_W-1:0] ALU_SUB    = 5'b10110;
   localparam logic [ALU_W-1:0] ALU_AND    = 5'b10111;
   localparam logic [ALU_W-1:0] ALU_ORR    = 5'b11000;

   // Register enables are active-low; ARF bit order {PC,AR,SP}.
   localparam logic [ARF_N-1:0] ARF_EN_NONE = 3'b111;
   localparam logic [ARF_N-1:0] ARF_EN_ALL  = 3'b000;
   localparam logic [ARF_N-1:0] ARF_EN_PC   = 3'b011;
   localparam logic [ARF_N-1:0] ARF_EN_AR   = 3'b101;
   localparam logic [RF_N-1:0]  RF_EN_NONE  = 4'b1111;
   localparam logic [RF_N-1:0]  RF_EN_ALL   = 4'b0000;

   localparam logic [1:0] ARF_SEL_PC = 2'b00;
   localparam logic [1:0] ARF_SEL_AR = 2'b10;
   localparam logic [1:0] MUXA_ALU   = 2'b00;
   localparam logic [1:0] MUXA_MEM   = 2'b10;
   localparam logic [1:0] MUXA_IR    = 2'b11;
   localparam logic [1:0] MUXB_IR    = 2'b11;

   typedef struct packed {
      logic [2:0]       rf_outasel;
      logic [2:0]       rf_outbsel;
      logic [FUN_W-1:0] rf_funsel;
      logic [RF_N-1:0]  rf_regsel;
      logic [RF_N-1:0]  rf_scrsel;
      logic [ALU_W-1:0] alu_funsel;
      logic             alu_wf;
      logic [1:0]       arf_outcsel;
      logic [1:0]       arf_outdsel;
      logic [FUN_W-1:0] arf_funsel;
      logic [ARF_N-1:0] arf_regsel;
      logic             ir_lh;
      logic             ir_write;
      logic             mem_wr;
      logic             mem_cs;
      logic [1:0]       muxasel;
      logic [1:0]       muxbsel;
      logic             muxcsel;
   } ctrl_t;

   // Idle control word: nothing enabled, memory deselected, selects zero.
   function automatic ctrl_t ctrl_default();
      ctrl_t c;
      c            = '0;
      c.rf_regsel  = RF_EN_NONE;
      c.rf_scrsel  = RF_EN_NONE;
      c.arf_regsel = ARF_EN_NONE;
      c.mem_cs     = 1'b1;
      return c;
   endfunction

   // Active-low enable for RF register Rx, bit order {R1..R4}.
   function automatic logic [RF_N-1:0] rf_en(input logic [1:0] rx);
      return ~(4'b1000 >> rx);
   endfunction

endpackage

// File: rtl/seq_decoder.sv
// Combinational control-word decode from state, instruction and flags.
module seq_decoder
   import seq_pkg::*;
(
   input  state_e      state_i,
   input  logic [15:0] ir_i,
   input  logic [3:0]  flags_i,
   output ctrl_t       ctrl_c
);

   logic [OP_W-1:0] opcode;
   logic [1:0]      rx;
   logic [1:0]      ry;
   logic            unused_bits;

   assign opcode      = ir_i[15:10];
   assign rx          = ir_i[9:8];
   assign ry          = ir_i[7:6];
   // Immediate reaches the datapath through the IR mux, not through here.
   assign unused_bits = ^{ir_i[5:0], flags_i[2:0]};

   // Moore decode of the current step into the datapath control word.
   always_comb begin
      ctrl_c = ctrl_default();
      case (state_i)
         S_CLEAR: begin
            ctrl_c.rf_funsel  = FUN_CLR;
            ctrl_c.rf_regsel  = RF_EN_ALL;
            ctrl_c.arf_funsel = FUN_CLR;
            ctrl_c.arf_regsel = ARF_EN_ALL;
         end
         S_FETCH_LO, S_FETCH_HI: begin
            ctrl_c.arf_outdsel = ARF_SEL_PC;
            ctrl_c.mem_cs      = 1'b0;
            ctrl_c.ir_write    = 1'b1;
            ctrl_c.ir_lh       = (state_i == S_FETCH_HI);
            ctrl_c.arf_funsel  = FUN_INC;
            ctrl_c.arf_regsel  = ARF_EN_PC;
         end
         S_EXEC1: begin
            case (opcode)
               OP_BRA, OP_BNE: begin
                  // BNE branches only when Z is clear.
                  if (opcode == OP_BRA || !flags_i[3]) begin
                     ctrl_c.muxbsel    = MUXB_IR;
                     ctrl_c.arf_funsel = FUN_LOAD;
                     ctrl_c.arf_regsel = ARF_EN_PC;
                  end
               end
               OP_LDI: begin
                  ctrl_c.muxasel   = MUXA_IR;
                  ctrl_c.rf_funsel = FUN_LOAD;
                  ctrl_c.rf_regsel = rf_en(rx);
               end
               OP_LD, OP_ST: begin
                  ctrl_c.muxbsel    = MUXB_IR;
                  ctrl_c.arf_funsel = FUN_LOAD;
                  ctrl_c.arf_regsel = ARF_EN_AR;
               end
               OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                  ctrl_c.rf_outasel = 3'({1'b0, rx});
                  ctrl_c.rf_outbsel = 3'({1'b0, ry});
                  ctrl_c.alu_wf     = 1'b1;
                  ctrl_c.muxasel    = MUXA_ALU;
                  ctrl_c.rf_funsel  = FUN_LOAD;
                  ctrl_c.rf_regsel  = rf_en(rx);
                  case (opcode)
                     OP_ADD:  ctrl_c.alu_funsel = ALU_ADD;
                     OP_SUB:  ctrl_c.alu_funsel = ALU_SUB;
                     OP_AND:  ctrl_c.alu_funsel = ALU_AND;
                     default: ctrl_c.alu_funsel = ALU_ORR;
                  endcase
               end
               default: ;
            endcase
         end
         S_EXEC2: begin
            case (opcode)
               OP_LD: begin
                  ctrl_c.arf_outdsel = ARF_SEL_AR;
                  ctrl_c.mem_cs      = 1'b0;
                  ctrl_c.muxasel     = MUXA_MEM;
                  ctrl_c.rf_funsel   = FUN_LOAD;
                  ctrl_c.rf_regsel   = rf_en(rx);
               end
               OP_ST: begin
                  ctrl_c.rf_outasel  = 3'({1'b0, rx});
                  ctrl_c.alu_funsel  = ALU_PASS_A;
                  ctrl_c.muxcsel     = 1'b0;
                  ctrl_c.arf_outdsel = ARF_SEL_AR;
                  ctrl_c.mem_cs      = 1'b0;
                  ctrl_c.mem_wr      = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/execute sequencer: state register, step sequencing and control fan-out.
module instruction_sequencer
   import seq_pkg::*;
(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [15:0]      IROut,
   input  logic [3:0]       Flags,
   output logic [2:0]       RF_OutASel,
   output logic [2:0]       RF_OutBSel,
   output logic [FUN_W-1:0] RF_FunSel,
   output logic [RF_N-1:0]  RF_RegSel,
   output logic [RF_N-1:0]  RF_ScrSel,
   output logic [ALU_W-1:0] ALU_FunSel,
   output logic             ALU_WF,
   output logic [1:0]       ARF_OutCSel,
   output logic [1:0]       ARF_OutDSel,
   output logic [FUN_W-1:0] ARF_FunSel,
   output logic [ARF_N-1:0] ARF_RegSel,
   output logic             IR_LH,
   output logic             IR_Write,
   output logic             Mem_WR,
   output logic             Mem_CS,
   output logic [1:0]       MuxASel,
   output logic [1:0]       MuxBSel,
   output logic             MuxCSel,
   output logic [T_W-1:0]   T,
   output logic             Halted
);

   state_e          state_q;
   state_e          state_d;
   ctrl_t           ctrl_c;
   logic [OP_W-1:0] opcode;

   assign opcode = IROut[15:10];

   // State register; reset lands in CLEAR from any state.
   always_ff @(posedge Clock) begin
      if (Reset) state_q <= S_CLEAR;
      else       state_q <= state_d;
   end

   // Step sequencing; only LD/ST need a second execute step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR:    state_d = S_IDLE;
         S_IDLE:     if (Start) state_d = S_FETCH_LO;
         S_FETCH_LO: state_d = S_FETCH_HI;
         S_FETCH_HI: state_d = S_EXEC1;
         S_EXEC1: begin
            if (opcode == OP_LD || opcode == OP_ST) state_d = S_EXEC2;
            else if (opcode == OP_HLT)              state_d = S_HALT;
            else                                    state_d = S_FETCH_LO;
         end
         S_EXEC2:    state_d = S_FETCH_LO;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_CLEAR;
      endcase
   end

   // One-based step number, zero outside the fetch/execute loop.
   always_comb begin
      T = 3'd0;
      case (state_q)
         S_FETCH_LO: T = 3'd1;
         S_FETCH_HI: T = 3'd2;
         S_EXEC1:    T = 3'd3;
         S_EXEC2:    T = 3'd4;
         default:    T = 3'd0;
      endcase
   end

   assign Halted = (state_q == S_HALT);

   seq_decoder u_decoder (
      .state_i (state_q),
      .ir_i    (IROut),
      .flags_i (Flags),
      .ctrl_c  (ctrl_c)
   );

   assign RF_OutASel  = ctrl_c.rf_outasel;
   assign RF_OutBSel  = ctrl_c.rf_outbsel;
   assign RF_FunSel   = ctrl_c.rf_funsel;
   assign RF_RegSel   = ctrl_c.rf_regsel;
   assign RF_ScrSel   = ctrl_c.rf_scrsel;
   assign ALU_FunSel  = ctrl_c.alu_funsel;
   assign ALU_WF      = ctrl_c.alu_wf;
   assign ARF_OutCSel = ctrl_c.arf_outcsel;
   assign ARF_OutDSel = ctrl_c.arf_outdsel;
   assign ARF_FunSel  = ctrl_c.arf_funsel;
   assign ARF_RegSel  = ctrl_c.arf_regsel;
   assign IR_LH       = ctrl_c.ir_lh;
   assign IR_Write    = ctrl_c.ir_write;
   assign Mem_WR      = ctrl_c.mem_wr;
   assign Mem_CS      = ctrl_c.mem_cs;
   assign MuxASel     = ctrl_c.muxasel;
   assign MuxBSel     = ctrl_c.muxbsel;
   assign MuxCSel     = ctrl_c.muxcsel;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with hand-computed expectations.
module tb_instruction_sequencer;

   logic        Clock = 1'b0;
   logic        Reset, Start;
   logic [15:0] IROut;
   logic [3:0]  Flags;
   logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel, ARF_FunSel, ARF_RegSel, T;
   logic [3:0]  RF_RegSel, RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel, MuxASel, MuxBSel;
   logic        ALU_WF, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxCSel, Halted;

   int n_checks = 0;
   int n_pass   = 0;

   instruction_sequencer dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .IROut(IROut), .Flags(Flags),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
      .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
      .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
      .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
      .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .T(T), .Halted(Halted)
   );

   always #5 Clock = ~Clock;

   // Count one comparison and report it if it differs.
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Two fetch steps, presenting the instruction during the first.
   task automatic fetch(input logic [15:0] ir);
      tick();
      check("fetch_lo_T", 16'(T), 16'd1);
      check("fetch_lo_lh", 16'(IR_LH), 16'd0);
      IROut = ir;
      tick();
      check("fetch_hi_T", 16'(T), 16'd2);
      check("fetch_hi_lh", 16'(IR_LH), 16'd1);
      #1;
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; IROut = 16'h0000; Flags = 4'b0000;

      // Reset held for two edges stays in CLEAR.
      tick();
      tick();
      check("clr_rf_regsel", 16'(RF_RegSel), 16'h0);
      check("clr_rf_fun", 16'(RF_FunSel), 16'h3);
      check("clr_arf_regsel", 16'(ARF_RegSel), 16'h0);
      check("clr_arf_fun", 16'(ARF_FunSel), 16'h3);
      check("clr_T", 16'(T), 16'd0);
      check("clr_halted", 16'(Halted), 16'd0);
      check("clr_mem_cs", 16'(Mem_CS), 16'd1);
      Reset = 1'b0;

      // Single CLEAR cycle then IDLE with all defaults.
      tick();
      check("idle_T", 16'(T), 16'd0);
      check("idle_rf_regsel", 16'(RF_RegSel), 16'hF);
      check("idle_arf_regsel", 16'(ARF_RegSel), 16'h7);
      check("idle_scr", 16'(RF_ScrSel), 16'hF);
      tick();
      check("idle_stay_T", 16'(T), 16'd0);
      Start = 1'b1;

      // First fetch step: PC drives memory, IR low byte, PC increments.
      tick();
      check("f1_T", 16'(T), 16'd1);
      check("f1_irw", 16'(IR_Write), 16'd1);
      check("f1_lh", 16'(IR_LH), 16'd0);
      check("f1_arf_regsel", 16'(ARF_RegSel), 16'h3);
      check("f1_arf_fun", 16'(ARF_FunSel), 16'h1);
      check("f1_mem_cs", 16'(Mem_CS), 16'd0);
      check("f1_outd", 16'(ARF_OutDSel), 16'h0);
      Start = 1'b0;
      IROut = 16'h0542;
      tick();
      check("f2_T", 16'(T), 16'd2);
      check("f2_lh", 16'(IR_LH), 16'd1);
      check("f2_irw", 16'(IR_Write), 16'd1);
      check("f2_arf_regsel", 16'(ARF_RegSel), 16'h3);

      // LDI R2,0x42
      tick();
      check("ldi_T", 16'(T), 16'd3);
      check("ldi_muxa", 16'(MuxASel), 16'h3);
      check("ldi_rf_regsel", 16'(RF_RegSel), 16'hB);
      check("ldi_rf_fun", 16'(RF_FunSel), 16'h2);
      check("ldi_arf_regsel", 16'(ARF_RegSel), 16'h7);

      // ST R4,0x10 encodes as opcode 0x03 -> 0x0F10.
      fetch(16'h0F10);
      tick();
      check("st1_T", 16'(T), 16'd3);
      check("st1_arf_regsel", 16'(ARF_RegSel), 16'h5);
      check("st1_arf_fun", 16'(ARF_FunSel), 16'h2);
      check("st1_muxb", 16'(MuxBSel), 16'h3);
      tick();
      check("st2_T", 16'(T), 16'd4);
      check("st2_mem_cs", 16'(Mem_CS), 16'd0);
      check("st2_mem_wr", 16'(Mem_WR), 16'd1);
      check("st2_outa", 16'(RF_OutASel), 16'h3);
      check("st2_outd", 16'(ARF_OutDSel), 16'h2);
      check("st2_alu", 16'(ALU_FunSel), 16'h10);
      check("st2_rf_regsel", 16'(RF_RegSel), 16'hF);

      // ADD R1,R3 -> 0x1080
      fetch(16'h1080);
      tick();
      check("add_alu", 16'(ALU_FunSel), 16'h14);
      check("add_wf", 16'(ALU_WF), 16'd1);
      check("add_outa", 16'(RF_OutASel), 16'h0);
      check("add_outb", 16'(RF_OutBSel), 16'h2);
      check("add_rf_regsel", 16'(RF_RegSel), 16'h7);
      check("add_rf_fun", 16'(RF_FunSel), 16'h2);

      // ORR R4,R2 -> 0x1F40
      fetch(16'h1F40);
      tick();
      check("orr_alu", 16'(ALU_FunSel), 16'h18);
      check("orr_outa", 16'(RF_OutASel), 16'h3);
      check("orr_outb", 16'(RF_OutBSel), 16'h1);
      check("orr_rf_regsel", 16'(RF_RegSel), 16'hE);
      check("orr_muxa", 16'(MuxASel), 16'h0);

      // BNE with Z clear branches.
      Flags = 4'b0000;
      fetch(16'h2020);
      tick();
      check("bne_tk_arf_regsel", 16'(ARF_RegSel), 16'h3);
      check("bne_tk_arf_fun", 16'(ARF_FunSel), 16'h2);
      check("bne_tk_muxb", 16'(MuxBSel), 16'h3);

      // BNE with Z set falls through.
      Flags = 4'b1000;
      fetch(16'h2020);
      tick();
      check("bne_nt_arf_regsel", 16'(ARF_RegSel), 16'h7);
      check("bne_nt_muxb", 16'(MuxBSel), 16'h0);
      Flags = 4'b0000;

      // Undefined opcode 0x09 acts as NOP and returns to fetch.
      fetch(16'h2400);
      tick();
      check("nop_T", 16'(T), 16'd3);
      check("nop_rf_regsel", 16'(RF_RegSel), 16'hF);
      check("nop_arf_regsel", 16'(ARF_RegSel), 16'h7);
      check("nop_mem_cs", 16'(Mem_CS), 16'd1);
      tick();
      check("nop_next_T", 16'(T), 16'd1);

      // LD R4,0x10 interrupted by reset during its second execute step.
      IROut = 16'h0B10;
      tick();
      tick();
      check("ld1_T", 16'(T), 16'd3);
      check("ld1_arf_regsel", 16'(ARF_RegSel), 16'h5);
      tick();
      check("ld2_T", 16'(T), 16'd4);
      check("ld2_mem_cs", 16'(Mem_CS), 16'd0);
      check("ld2_muxa", 16'(MuxASel), 16'h2);
      check("ld2_rf_regsel", 16'(RF_RegSel), 16'hE);
      Reset = 1'b1;
      tick();
      check("ldrst_T", 16'(T), 16'd0);
      check("ldrst_mem_cs", 16'(Mem_CS), 16'd1);
      check("ldrst_rf_fun", 16'(RF_FunSel), 16'h3);
      check("ldrst_rf_regsel", 16'(RF_RegSel), 16'h0);
      check("ldrst_muxa", 16'(MuxASel), 16'h0);
      Reset = 1'b0;
      tick();
      check("ldrst_idle_T", 16'(T), 16'd0);
      check("ldrst_idle_regsel", 16'(RF_RegSel), 16'hF);

      // HLT parks in HALT regardless of Start.
      Start = 1'b1;
      fetch(16'hFC00);
      tick();
      check("hlt_T", 16'(T), 16'd3);
      check("hlt_halted_e1", 16'(Halted), 16'd0);
      check("hlt_arf_regsel", 16'(ARF_RegSel), 16'h7);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("halt_halted", 16'(Halted), 16'd1);
         check("halt_T", 16'(T), 16'd0);
      end
      check("halt_mem_cs", 16'(Mem_CS), 16'd1);

      // Reset leaves HALT through CLEAR and IDLE.
      Reset = 1'b1;
      tick();
      check("hrst_halted", 16'(Halted), 16'd0);
      check("hrst_rf_regsel", 16'(RF_RegSel), 16'h0);
      Reset = 1'b0;
      tick();
      check("hrst_idle_T", 16'(T), 16'd0);
      check("hrst_idle_arf", 16'(ARF_RegSel), 16'h7);
      tick();
      check("hrst_restart_T", 16'(T), 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
